ibex_wb_host_bridge: RTL and testbench

IBEX_WB_HOST_BRIDGE -- requirements
Module: ibex_wb_host_bridge

---
 rtl/ibex_wb_pkg.sv | 15 +
 rtl/ibex_wb_host_bridge_if.sv | 44 ++++
 rtl/ibex_wb_host_bridge.sv | 178 +++++++++++++++++
 tb/tb_ibex_wb_host_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_wb_pkg.sv
// Shared state encoding and default parameters for the Ibex-to-Wishbone host bridge.
package ibex_wb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACTIVE = 2'd1;
  localparam state_t ABORT  = 2'd2;

  localparam int unsigned DefaultDataWidth      = 32;
  localparam int unsigned DefaultAddressWidth   = 32;
  localparam int unsigned DefaultMaxOutstanding = 2;
  localparam int unsigned DefaultTimeoutCycles  = 1024;

endpackage

// File: rtl/ibex_wb_host_bridge_if.sv
// Ibex data port plus pipelined Wishbone master port; names are from the bridge's point of view.
interface ibex_wb_host_bridge_if
  import ibex_wb_pkg::*;
#(
  parameter int unsigned DataWidth    = DefaultDataWidth,
  parameter int unsigned AddressWidth = DefaultAddressWidth
);

  logic                    host_req_i;
  logic                    host_gnt_o;
  logic [AddressWidth-1:0] host_addr_i;
  logic                    host_we_i;
  logic [DataWidth/8-1:0]  host_be_i;
  logic [DataWidth-1:0]    host_wdata_i;
  logic                    host_rvalid_o;
  logic [DataWidth-1:0]    host_rdata_o;
  logic                    host_err_o;

  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_we_o;
  logic [AddressWidth-1:0] wb_addr_o;
  logic [DataWidth-1:0]    wb_data_o;
  logic [DataWidth/8-1:0]  wb_sel_o;
  logic                    wb_stall_i;
  logic                    wb_ack_i;
  logic                    wb_err_i;
  logic [DataWidth-1:0]    wb_data_i;

  modport master (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
    input  wb_stall_i, wb_ack_i, wb_err_i, wb_data_i
  );

  modport slave (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
    output wb_stall_i, wb_ack_i, wb_err_i, wb_data_i
  );

endinterface

// File: rtl/ibex_wb_host_bridge.sv
// Bridges the Ibex data request/grant/rvalid protocol onto a pipelined Wishbone master with
// bounded outstanding requests, a response timeout and in-order error flushing on abort.
module ibex_wb_host_bridge
  import ibex_wb_pkg::*;
#(
  parameter int unsigned DataWidth      = DefaultDataWidth,
  parameter int unsigned AddressWidth   = DefaultAddressWidth,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  parameter int unsigned TimeoutCycles  = DefaultTimeoutCycles
) (
  input logic                   clk_i,
  input logic                   rst_i,
  ibex_wb_host_bridge_if.master bus_io
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned TmoWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TimeoutCycles - 1);
  localparam logic [2:0]          MaxOut  = 3'(MaxOutstanding);

  state_t                  state_q, state_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [BeWidth-1:0]      sel_q, sel_d;
  logic [DataWidth-1:0]    data_q, data_d;
  logic [2:0]              out_cnt_q, out_cnt_d, out_after;
  logic [2:0]              abort_cnt_q, abort_cnt_d;
  logic [TmoWidth-1:0]     tmo_q, tmo_d;
  // Write flag per outstanding request so read data can be zeroed for write acks.
  logic [3:0]              we_fifo_q, we_fifo_d;
  logic [1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                    rvalid_q, rvalid_d, err_q, err_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;

  logic active, issue, retire, bus_err, timeout, abort_go, gnt, accept, stb_hold;

  assign active    = (state_q == ACTIVE);
  assign issue     = stb_q & ~bus_io.wb_stall_i;
  assign retire    = active & (out_cnt_q != 3'd0) & (bus_io.wb_ack_i | bus_io.wb_err_i);
  assign bus_err   = retire & bus_io.wb_err_i;
  assign timeout   = active & (out_cnt_q != 3'd0) & ~bus_io.wb_ack_i & ~bus_io.wb_err_i &
                     (tmo_q == TmoLast);
  assign abort_go  = bus_err | timeout;
  assign out_after = out_cnt_q + {2'b00, issue} - {2'b00, retire};
  assign stb_hold  = stb_q & bus_io.wb_stall_i;
  assign gnt       = ~rst_i & ((state_q == IDLE) | active) & (~stb_q | ~bus_io.wb_stall_i) &
                     (out_after < MaxOut);
  assign accept    = bus_io.host_req_i & gnt;

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    data_d      = data_q;
    out_cnt_d   = out_after;
    abort_cnt_d = abort_cnt_q;
    tmo_d       = tmo_q;
    we_fifo_d   = we_fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;

    if (accept) begin
      stb_d  = 1'b1;
      we_d   = bus_io.host_we_i;
      addr_d = bus_io.host_addr_i;
      sel_d  = bus_io.host_be_i;
      data_d = bus_io.host_wdata_i;
    end else if (issue) begin
      stb_d = 1'b0;
    end

    if (issue) begin
      we_fifo_d[wr_ptr_q] = we_q;
      wr_ptr_d            = wr_ptr_q + 2'd1;
    end

    if (retire) begin
      rvalid_d = 1'b1;
      err_d    = bus_io.wb_err_i;
      rdata_d  = (we_fifo_q[rd_ptr_q] | bus_io.wb_err_i) ? '0 : bus_io.wb_data_i;
      rd_ptr_d = rd_ptr_q + 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (abort_go) begin
          // The failing (oldest) request answers now; everything behind it drains in ABORT.
          state_d     = ABORT;
          rvalid_d    = 1'b1;
          err_d       = 1'b1;
          rdata_d     = '0;
          abort_cnt_d = out_after + {2'b00, accept | stb_hold} - {2'b00, timeout};
          stb_d       = 1'b0;
          out_cnt_d   = 3'd0;
          wr_ptr_d    = 2'd0;
          rd_ptr_d    = 2'd0;
        end else if (!stb_q && (out_cnt_q == 3'd0) && !accept) begin
          state_d = IDLE;
        end
      end
      ABORT: begin
        stb_d     = 1'b0;
        out_cnt_d = 3'd0;
        if (abort_cnt_q != 3'd0) begin
          rvalid_d    = 1'b1;
          err_d       = 1'b1;
          abort_cnt_d = abort_cnt_q - 3'd1;
        end
        if (abort_cnt_q <= 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!active || (state_d != ACTIVE) || issue || bus_io.wb_ack_i || bus_io.wb_err_i) begin
      tmo_d = '0;
    end else if (out_cnt_q != 3'd0) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      data_q      <= '0;
      out_cnt_q   <= 3'd0;
      abort_cnt_q <= 3'd0;
      tmo_q       <= '0;
      we_fifo_q   <= 4'd0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      out_cnt_q   <= out_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      tmo_q       <= tmo_d;
      we_fifo_q   <= we_fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_io.host_gnt_o    = gnt;
  assign bus_io.host_rvalid_o = rvalid_q;
  assign bus_io.host_rdata_o  = rdata_q;
  assign bus_io.host_err_o    = err_q;

  assign bus_io.wb_cyc_o  = active & (stb_q | (out_cnt_q != 3'd0));
  assign bus_io.wb_stb_o  = stb_q;
  assign bus_io.wb_we_o   = we_q;
  assign bus_io.wb_addr_o = addr_q;
  assign bus_io.wb_sel_o  = sel_q;
  assign bus_io.wb_data_o = data_q;

endmodule

// File: tb/tb_ibex_wb_host_bridge.sv
// Directed bench for ibex_wb_host_bridge: scripted Wishbone slave, response scoreboard queue.
module tb_ibex_wb_host_bridge;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  int   silent;
  resp_t exp_q[$];
  resp_t mon_exp;

  always #5 clk = ~clk;

  ibex_wb_host_bridge_if #(.DataWidth(32), .AddressWidth(32)) bus ();

  ibex_wb_host_bridge #(
    .DataWidth     (32),
    .AddressWidth  (32),
    .MaxOutstanding(2),
    .TimeoutCycles (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    bus.host_gnt_o, 0);
    check({tag, "_rvalid"}, bus.host_rvalid_o, 0);
    check({tag, "_rdata"},  bus.host_rdata_o, 0);
    check({tag, "_err"},    bus.host_err_o, 0);
    check({tag, "_cyc"},    bus.wb_cyc_o, 0);
    check({tag, "_stb"},    bus.wb_stb_o, 0);
    check({tag, "_we"},     bus.wb_we_o, 0);
    check({tag, "_addr"},   bus.wb_addr_o, 0);
    check({tag, "_wdata"},  bus.wb_data_o, 0);
    check({tag, "_sel"},    bus.wb_sel_o, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic err, input logic [31:0] data);
    exp_q.push_back({err, data});
    n_pushed++;
  endtask

  task automatic host(input logic req, input logic [31:0] addr, input logic we,
                      input logic [31:0] wdata);
    bus.host_req_i   = req;
    bus.host_addr_i  = addr;
    bus.host_we_i    = we;
    bus.host_be_i    = 4'hF;
    bus.host_wdata_i = wdata;
  endtask

  // Every response is matched in order against the scoreboard.
  always @(negedge clk) begin
    if (bus.host_rvalid_o) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL resp_unexpected observed=err%0d/%0h expected=no_response",
               bus.host_err_o, bus.host_rdata_o);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        n_popped++;
        checks++;
        assert ({bus.host_err_o, bus.host_rdata_o} === mon_exp) else begin
          failures++;
          $error("FAIL resp_%0d observed=err%0d/%0h expected=err%0d/%0h", n_popped,
                 bus.host_err_o, bus.host_rdata_o, mon_exp.err, mon_exp.data);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    host(1'b1, 32'h0, 1'b0, 32'h0);
    bus.wb_stall_i = 1'b0;
    bus.wb_ack_i   = 1'b0;
    bus.wb_err_i   = 1'b0;
    bus.wb_data_i  = 32'h0;

    // Reset state, grant held low even with a request pending
    sample();
    check_all_zero("reset");
    next_cycle(); rst = 1'b0; host(1'b0, 32'h0, 1'b0, 32'h0);
    sample(); check("idle_gnt", bus.host_gnt_o, 1);

    // Single read, ack one cycle after issue
    next_cycle(); host(1'b1, 32'h8000_0000, 1'b0, 32'h0);
    sample(); check("rd_gnt", bus.host_gnt_o, 1);
    next_cycle(); bus.host_req_i = 1'b0;
    sample();
    check("rd_stb", bus.wb_stb_o, 1);
    check("rd_cyc", bus.wb_cyc_o, 1);
    check("rd_addr", bus.wb_addr_o, 32'h8000_0000);
    check("rd_we", bus.wb_we_o, 0);
    next_cycle(); bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'hDEAD_BEEF; push(1'b0, 32'hDEAD_BEEF);
    sample(); check("rd_no_early_rvalid", bus.host_rvalid_o, 0);
    next_cycle(); bus.wb_ack_i = 1'b0; bus.wb_data_i = 32'h0;
    sample();
    check("rd_rvalid_lat", bus.host_rvalid_o, 1);
    check("rd_cyc_done", bus.wb_cyc_o, 0);

    // Back-to-back writes with a three-cycle stall
    next_cycle(); host(1'b1, 32'h0000_0100, 1'b1, 32'h1111_1111);
    sample(); check("wr_gnt_a", bus.host_gnt_o, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); host(1'b1, 32'h0000_0104, 1'b1, 32'h2222_2222); bus.wb_stall_i = 1'b1;
      sample();
      check("wr_stall_gnt", bus.host_gnt_o, 0);
      check("wr_stall_stb", bus.wb_stb_o, 1);
      check("wr_stall_addr", bus.wb_addr_o, 32'h0000_0100);
      check("wr_stall_data", bus.wb_data_o, 32'h1111_1111);
      check("wr_stall_we", bus.wb_we_o, 1);
    end
    next_cycle(); bus.wb_stall_i = 1'b0;
    sample(); check("wr_gnt_b", bus.host_gnt_o, 1);
    next_cycle(); bus.host_req_i = 1'b0;
    sample();
    check("wr_b_addr", bus.wb_addr_o, 32'h0000_0104);
    check("wr_b_data", bus.wb_data_o, 32'h2222_2222);
    check("wr_full_gnt", bus.host_gnt_o, 0);
    next_cycle(); bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'hCAFE_F00D; push(1'b0, 32'h0);
    sample();
    next_cycle(); push(1'b0, 32'h0);
    sample(); check("wr_rvalid_a", bus.host_rvalid_o, 1);
    next_cycle(); bus.wb_ack_i = 1'b0; bus.wb_data_i = 32'h0;
    sample(); check("wr_rvalid_b", bus.host_rvalid_o, 1);
    next_cycle();
    sample(); check("wr_idle_cyc", bus.wb_cyc_o, 0);

    // Three reads, acks five cycles after issue: third grant waits for first ack
    next_cycle(); host(1'b1, 32'h0000_0200, 1'b0, 32'h0);
    sample(); check("mo_gnt_a", bus.host_gnt_o, 1);
    next_cycle(); bus.host_addr_i = 32'h0000_0204;
    sample(); check("mo_gnt_b", bus.host_gnt_o, 1);
    next_cycle(); bus.host_addr_i = 32'h0000_0208;
    sample(); check("mo_gnt_full", bus.host_gnt_o, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sample(); check("mo_gnt_held", bus.host_gnt_o, 0);
    end
    next_cycle(); bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'hA0A0_A0A0; push(1'b0, 32'hA0A0_A0A0);
    sample(); check("mo_gnt_c", bus.host_gnt_o, 1);
    next_cycle(); bus.host_req_i = 1'b0; bus.wb_data_i = 32'hB0B0_B0B0; push(1'b0, 32'hB0B0_B0B0);
    sample(); check("mo_c_addr", bus.wb_addr_o, 32'h0000_0208);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); bus.wb_ack_i = 1'b0; bus.wb_data_i = 32'h0;
      sample();
    end
    next_cycle(); bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'hC0C0_C0C0; push(1'b0, 32'hC0C0_C0C0);
    sample();
    next_cycle(); bus.wb_ack_i = 1'b0; bus.wb_data_i = 32'h0;
    sample(); check("mo_rvalid_c", bus.host_rvalid_o, 1);
    next_cycle();
    sample(); check("mo_idle_cyc", bus.wb_cyc_o, 0);

    // Two outstanding, error on the first: both answered with err, then back to idle
    next_cycle(); host(1'b1, 32'h0000_0300, 1'b0, 32'h0);
    sample();
    next_cycle(); bus.host_addr_i = 32'h0000_0304;
    sample(); check("er_gnt_b", bus.host_gnt_o, 1);
    next_cycle(); bus.host_req_i = 1'b0;
    sample(); check("er_cyc", bus.wb_cyc_o, 1);
    next_cycle(); bus.wb_err_i = 1'b1; push(1'b1, 32'h0); push(1'b1, 32'h0);
    sample();
    next_cycle(); bus.wb_err_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_data_i = 32'h1234_5678;
    sample();
    check("er_rvalid_1", bus.host_rvalid_o, 1);
    check("er_err_1", bus.host_err_o, 1);
    check("er_abort_cyc", bus.wb_cyc_o, 0);
    check("er_abort_gnt", bus.host_gnt_o, 0);
    next_cycle(); bus.wb_ack_i = 1'b0;
    sample();
    check("er_rvalid_2", bus.host_rvalid_o, 1);
    check("er_err_2", bus.host_err_o, 1);
    next_cycle(); bus.wb_ack_i = 1'b1;
    sample();
    check("er_done_rvalid", bus.host_rvalid_o, 0);
    check("er_idle_gnt", bus.host_gnt_o, 1);
    next_cycle(); bus.wb_ack_i = 1'b0; bus.wb_data_i = 32'h0;
    sample(); check("stray_ack_rvalid", bus.host_rvalid_o, 0);

    // Silent slave: abort after sixteen idle cycles
    next_cycle(); host(1'b1, 32'h0000_0400, 1'b0, 32'h0);
    sample();
    next_cycle(); bus.host_req_i = 1'b0;
    sample(); check("to_stb", bus.wb_stb_o, 1);
    push(1'b1, 32'h0);
    silent = 0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      sample();
      if (!bus.wb_cyc_o) break;
      silent++;
    end
    check("to_silent_cycles", silent, 16);
    check("to_rvalid", bus.host_rvalid_o, 1);
    check("to_err", bus.host_err_o, 1);
    next_cycle();
    sample(); check("to_idle_gnt", bus.host_gnt_o, 1);

    // Asynchronous reset in the middle of two writes
    next_cycle(); host(1'b1, 32'h0000_0500, 1'b1, 32'h5555_5555);
    sample();
    next_cycle(); bus.host_addr_i = 32'h0000_0504;
    sample(); check("rs_cyc", bus.wb_cyc_o, 1);
    next_cycle(); bus.host_req_i = 1'b0;
    sample();
    next_cycle(); bus.host_req_i = 1'b1; rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    sample(); check("rst_hold_cyc", bus.wb_cyc_o, 0);
    next_cycle(); rst = 1'b0; bus.host_req_i = 1'b0; bus.wb_ack_i = 1'b1;
    sample();
    next_cycle(); bus.wb_ack_i = 1'b0;
    sample();
    check("rst_discard_rvalid", bus.host_rvalid_o, 0);
    check("rst_idle_gnt", bus.host_gnt_o, 1);

    repeat (3) next_cycle();
    sample();
    check("sb_drained", exp_q.size(), 0);
    check("sb_count", n_popped, n_pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
